// File: rtl/i2s_tx_scheduler.sv
// i2s_tx_scheduler: generates SCK/WS for a stereo I2S stream and hands one
// buffered sample per channel slot to a single-channel serializer.
//
// Ports:
//   clk, rst              system clock, synchronous active-low reset
//   en                    run request; stop only takes effect at the end of a frame
//   l_sample/l_valid/l_ready  left-channel one-deep buffer handshake
//   r_sample/r_valid/r_ready  right-channel one-deep buffer handshake
//   clr_status            clears the sticky underrun flags
//   sck, ws               serial clock and word select (0 = left, 1 = right)
//   audio_sample          sample presented to the serializer, held per slot
//   sample_valid          one-clk load strobe at each slot start
//   frame_tick            one-clk pulse at each left slot start
//   underrun_l/underrun_r sticky: a slot started with its buffer empty
//   busy                  high while running
module i2s_tx_scheduler #(
  parameter int unsigned CLK_DIV  = 1250,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned SLOT_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] l_sample,
  input  logic                l_valid,
  output logic                l_ready,
  input  logic [SAMPLE_W-1:0] r_sample,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic                clr_status,
  output logic                sck,
  output logic                ws,
  output logic [SAMPLE_W-1:0] audio_sample,
  output logic                sample_valid,
  output logic                frame_tick,
  output logic                underrun_l,
  output logic                underrun_r,
  output logic                busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                l_full;
  logic                r_full;
  logic [SAMPLE_W-1:0] l_buf;
  logic [SAMPLE_W-1:0] r_buf;

  logic div_last;
  logic fall;
  logic boundary;
  logic stop;
  logic start_l;
  logic start_r;
  logic l_acc;
  logic r_acc;

  // Ready is held low during reset regardless of buffer state
  assign l_ready = rst & ~l_full;
  assign r_ready = rst & ~r_full;
  assign l_acc   = l_valid & l_ready;
  assign r_acc   = r_valid & r_ready;

  // Timing events; boundary is the SCK fall ending the last bit of a slot
  assign div_last = (state == RUN) && (div_cnt == DIV_LAST);
  assign fall     = div_last && sck;
  assign boundary = fall && (bit_cnt == BIT_LAST);
  // en is only honoured at the end of a right slot so frames stay whole
  assign stop     = boundary && ws && !en;
  assign start_l  = ((state == IDLE) && en) || (boundary && ws && en);
  assign start_r  = boundary && !ws;

  // Sequencer, slot loading, status and buffer registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sck          <= 1'b0;
      ws           <= 1'b0;
      audio_sample <= '0;
      sample_valid <= 1'b0;
      frame_tick   <= 1'b0;
      underrun_l   <= 1'b0;
      underrun_r   <= 1'b0;
      busy         <= 1'b0;
      l_full       <= 1'b0;
      r_full       <= 1'b0;
      l_buf        <= '0;
      r_buf        <= '0;
    end else begin
      sample_valid <= 1'b0;
      frame_tick   <= 1'b0;
      if (clr_status) begin
        underrun_l <= 1'b0;
        underrun_r <= 1'b0;
      end

      if (state == IDLE) begin
        sck     <= 1'b0;
        ws      <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
        if (en) begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end else begin
        if (div_last) begin
          div_cnt <= '0;
          sck     <= ~sck;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (fall) begin
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        if (boundary) begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            sck   <= 1'b0;
            ws    <= 1'b0;
          end else begin
            ws <= ~ws;
          end
        end
      end

      // Slot start: load buffered sample or flag an underrun (set beats clear)
      if (start_l) begin
        sample_valid <= 1'b1;
        frame_tick   <= 1'b1;
        if (l_full) begin
          audio_sample <= l_buf;
        end else begin
          audio_sample <= '0;
          underrun_l   <= 1'b1;
        end
      end
      if (start_r) begin
        sample_valid <= 1'b1;
        if (r_full) begin
          audio_sample <= r_buf;
        end else begin
          audio_sample <= '0;
          underrun_r   <= 1'b1;
        end
      end

      // Consume then accept; an accept on a boundary lands in the next slot
      if (start_l) l_full <= 1'b0;
      if (l_acc) begin
        l_full <= 1'b1;
        l_buf  <= l_sample;
      end
      if (start_r) r_full <= 1'b0;
      if (r_acc) begin
        r_full <= 1'b1;
        r_buf  <= r_sample;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler with CLK_DIV=2, SLOT_W=4 (16-clk slots).
module tb_i2s_tx_scheduler;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned SLOT_W   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en = 1'b0;
  logic [SAMPLE_W-1:0] l_sample = '0;
  logic                l_valid = 1'b0;
  logic                l_ready;
  logic [SAMPLE_W-1:0] r_sample = '0;
  logic                r_valid = 1'b0;
  logic                r_ready;
  logic                clr_status = 1'b0;
  logic                sck;
  logic                ws;
  logic [SAMPLE_W-1:0] audio_sample;
  logic                sample_valid;
  logic                frame_tick;
  logic                underrun_l;
  logic                underrun_r;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;

  i2s_tx_scheduler #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .l_sample(l_sample), .l_valid(l_valid), .l_ready(l_ready),
    .r_sample(r_sample), .r_valid(r_valid), .r_ready(r_ready),
    .clr_status(clr_status), .sck(sck), .ws(ws), .audio_sample(audio_sample),
    .sample_valid(sample_valid), .frame_tick(frame_tick),
    .underrun_l(underrun_l), .underrun_r(underrun_r), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; l_valid = 1'b0; r_valid = 1'b0; clr_status = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0;
    tick(); tick();
    n_checks++;
    if ({sck, ws, sample_valid, frame_tick, underrun_l, underrun_r, busy} !== 7'b0)
      $display("FAIL reset_flags: got %b expected 0000000", {sck, ws, sample_valid, frame_tick, underrun_l, underrun_r, busy});
    else n_pass++;
    n_checks++;
    if (audio_sample !== 24'h0) $display("FAIL reset_audio: got %h expected 000000", audio_sample);
    else n_pass++;
    n_checks++;
    if ({l_ready, r_ready} !== 2'b00) $display("FAIL reset_ready_low: got %b expected 00", {l_ready, r_ready});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({l_ready, r_ready} !== 2'b11) $display("FAIL reset_ready_high: got %b expected 11", {l_ready, r_ready});
    else n_pass++;
  endtask

  task automatic test_startup();
    do_reset();
    l_sample = 24'hABCDEF; l_valid = 1'b1;
    r_sample = 24'h123456; r_valid = 1'b1;
    tick();
    l_valid = 1'b0; r_valid = 1'b0;
    n_checks++;
    if ({l_ready, r_ready} !== 2'b00) $display("FAIL start_loaded_ready: got %b expected 00", {l_ready, r_ready});
    else n_pass++;
    en = 1'b1;
    tick();
    for (int c = 0; c <= 16; c++) begin
      if (c == 0) begin
        n_checks++;
        if ({sample_valid, frame_tick, ws, busy} !== 4'b1101 || audio_sample !== 24'hABCDEF)
          $display("FAIL start_left: got sv/ft/ws/busy=%b audio=%h expected 1101 abcdef", {sample_valid, frame_tick, ws, busy}, audio_sample);
        else n_pass++;
      end
      if (c >= 1 && c <= 5) begin
        // sck rises after clk 2 and falls after clk 4
        n_checks++;
        if (sck !== ((c == 2 || c == 3) ? 1'b1 : 1'b0))
          $display("FAIL start_sck_c%0d: got %b expected %b", c, sck, (c == 2 || c == 3));
        else n_pass++;
      end
      if (c == 1) begin
        n_checks++;
        if (sample_valid !== 1'b0) $display("FAIL start_sv_pulse: got %b expected 0", sample_valid);
        else n_pass++;
      end
      if (c == 16) begin
        n_checks++;
        if ({sample_valid, frame_tick, ws} !== 3'b101 || audio_sample !== 24'h123456)
          $display("FAIL start_right: got sv/ft/ws=%b audio=%h expected 101 123456", {sample_valid, frame_tick, ws}, audio_sample);
        else n_pass++;
      end
      if (c < 16) tick();
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    do_reset();
    l_sample = 24'h100000; l_valid = 1'b1;
    r_sample = 24'h200000; r_valid = 1'b1;
    tick();
    en = 1'b1;
    tick();
    accepts = 0;
    for (int c = 0; c < 64; c++) begin
      if (c == 0 || c == 32) begin
        n_checks++;
        if (l_ready !== 1'b1) $display("FAIL bp_ready_rise_c%0d: got %b expected 1", c, l_ready);
        else n_pass++;
      end
      if (c == 1) begin
        n_checks++;
        if (l_ready !== 1'b0) $display("FAIL bp_ready_fall: got %b expected 0", l_ready);
        else n_pass++;
      end
      if (c == 16) begin
        n_checks++;
        if (ws !== 1'b1 || audio_sample !== 24'h200000)
          $display("FAIL bp_right: got ws=%b audio=%h expected 1 200000", ws, audio_sample);
        else n_pass++;
      end
      if (c == 32) begin
        n_checks++;
        if (frame_tick !== 1'b1 || audio_sample !== 24'h100001)
          $display("FAIL bp_second_left: got ft=%b audio=%h expected 1 100001", frame_tick, audio_sample);
        else n_pass++;
      end
      if (l_ready) begin
        accepts++;
        l_sample = 24'h100000 + 24'(accepts);
      end
      tick();
    end
    n_checks++;
    if (accepts !== 2) $display("FAIL bp_accept_count: got %0d expected 2", accepts);
    else n_pass++;
    n_checks++;
    if ({underrun_l, underrun_r} !== 2'b00) $display("FAIL bp_no_underrun: got %b expected 00", {underrun_l, underrun_r});
    else n_pass++;
  endtask

  task automatic test_underrun();
    do_reset();
    l_sample = 24'h0A0B0C; l_valid = 1'b1; r_valid = 1'b0;
    tick();
    en = 1'b1;
    tick();
    for (int c = 0; c <= 48; c++) begin
      clr_status = (c == 20 || c == 47);
      if (c == 15) begin
        n_checks++;
        if (underrun_r !== 1'b0) $display("FAIL ur_before: got %b expected 0", underrun_r);
        else n_pass++;
      end
      if (c == 16 || c == 48) begin
        // c==48 also has clr_status coinciding with the set: set wins
        n_checks++;
        if ({sample_valid, ws, underrun_r, underrun_l} !== 4'b1110 || audio_sample !== 24'h0)
          $display("FAIL ur_right_c%0d: got sv/ws/ur/ul=%b audio=%h expected 1110 000000", c, {sample_valid, ws, underrun_r, underrun_l}, audio_sample);
        else n_pass++;
      end
      if (c == 21) begin
        n_checks++;
        if (underrun_r !== 1'b0) $display("FAIL ur_clear: got %b expected 0", underrun_r);
        else n_pass++;
      end
      if (c == 32) begin
        n_checks++;
        if (underrun_l !== 1'b0 || audio_sample !== 24'h0A0B0C)
          $display("FAIL ur_left_ok: got ul=%b audio=%h expected 0 0a0b0c", underrun_l, audio_sample);
        else n_pass++;
      end
      if (c < 48) tick();
    end
    clr_status = 1'b0;
  endtask

  task automatic test_stop();
    int extra_sv;
    do_reset();
    l_sample = 24'hAAAAAA; l_valid = 1'b1;
    r_sample = 24'hBBBBBB; r_valid = 1'b1;
    tick();
    en = 1'b1;
    tick();
    extra_sv = 0;
    for (int c = 0; c <= 51; c++) begin
      if (c == 0) l_sample = 24'hCCCCCC;
      if (c == 2) l_sample = 24'hDDDDDD;
      if (c == 5) en = 1'b0;
      if (c == 16) begin
        n_checks++;
        if ({sample_valid, ws, busy} !== 3'b111) $display("FAIL stop_right_runs: got %b expected 111", {sample_valid, ws, busy});
        else n_pass++;
      end
      if (c == 31) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL stop_busy_final: got %b expected 1", busy);
        else n_pass++;
      end
      if (c == 32) begin
        n_checks++;
        if ({busy, sck, ws, sample_valid} !== 4'b0000) $display("FAIL stop_idle: got %b expected 0000", {busy, sck, ws, sample_valid});
        else n_pass++;
      end
      if (c > 32 && c <= 50 && sample_valid) extra_sv++;
      if (c == 50) en = 1'b1;
      if (c == 51) begin
        n_checks++;
        if ({sample_valid, frame_tick, ws, busy} !== 4'b1101 || audio_sample !== 24'hCCCCCC)
          $display("FAIL stop_restart: got sv/ft/ws/busy=%b audio=%h expected 1101 cccccc", {sample_valid, frame_tick, ws, busy}, audio_sample);
        else n_pass++;
      end
      if (c < 51) tick();
    end
    n_checks++;
    if (extra_sv !== 0) $display("FAIL stop_no_strobe: got %0d expected 0", extra_sv);
    else n_pass++;
  endtask

  task automatic test_boundary_accept_and_reset();
    do_reset();
    l_sample = 24'h333333; l_valid = 1'b1; r_valid = 1'b0;
    r_sample = 24'h5A5A5A;
    tick();
    en = 1'b1;
    tick();
    for (int c = 0; c <= 52; c++) begin
      if (c == 15) r_valid = 1'b1;
      if (c == 16) begin
        r_valid = 1'b0;
        n_checks++;
        if ({sample_valid, ws, underrun_r, r_ready} !== 4'b1110 || audio_sample !== 24'h0)
          $display("FAIL ba_underrun: got sv/ws/ur/rr=%b audio=%h expected 1110 000000", {sample_valid, ws, underrun_r, r_ready}, audio_sample);
        else n_pass++;
      end
      if (c == 48) begin
        n_checks++;
        if ({sample_valid, ws} !== 2'b11 || audio_sample !== 24'h5A5A5A)
          $display("FAIL ba_next_slot: got sv/ws=%b audio=%h expected 11 5a5a5a", {sample_valid, ws}, audio_sample);
        else n_pass++;
      end
      if (c < 52) tick();
    end
    // Mid-slot reset with left buffer full and flags set
    rst = 1'b0; en = 1'b0; l_valid = 1'b0;
    tick();
    n_checks++;
    if ({sck, ws, sample_valid, frame_tick, underrun_l, underrun_r, busy, l_ready, r_ready} !== 9'b0 || audio_sample !== 24'h0)
      $display("FAIL rst_mid_outputs: got %b audio=%h expected 000000000 000000", {sck, ws, sample_valid, frame_tick, underrun_l, underrun_r, busy, l_ready, r_ready}, audio_sample);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({l_ready, r_ready} !== 2'b11) $display("FAIL rst_mid_ready: got %b expected 11", {l_ready, r_ready});
    else n_pass++;
    tick(); tick(); tick();
    n_checks++;
    if ({busy, sck, ws, sample_valid} !== 4'b0000) $display("FAIL rst_mid_idle: got %b expected 0000", {busy, sck, ws, sample_valid});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_underrun();
    test_stop();
    test_boundary_accept_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
